// File: rtl/vga_fb_arbiter.sv
// Framebuffer RAM arbiter: display scan-out owns every 4th active pixel clock,
// host pixel writes are queued in a small FIFO and drain in the remaining cycles.
module vga_fb_arbiter #(
  parameter int H_ACTIVE   = 640,
  parameter int V_ACTIVE   = 480,
  parameter int FB_W       = 160,
  parameter int FB_H       = 120,
  parameter int ADDR_W     = 15,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk_25,
  input  logic              reset_n,
  input  logic [9:0]        h_count,
  input  logic [9:0]        v_count,
  input  logic              bright,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [2:0]        wr_data,
  input  logic              wr_vblank_only,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_we,
  output logic [2:0]        ram_wdata,
  input  logic [2:0]        ram_rdata,
  output logic [2:0]        rgb,
  output logic [2:0]        fifo_count
);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam logic [ADDR_W-1:0] FB_SIZE = ADDR_W'(FB_W * FB_H);

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [2:0]        data;
  } wr_req_t;

  wr_req_t          mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [PTR_W:0]   cnt_q, cnt_d;
  logic             rdy_en_q, slot_d1_q, bright_d1_q;
  logic [2:0]       pix_q;

  logic              full, empty, push, pop, disp_slot, vblank_ok, head_in_fb;
  logic [ADDR_W-1:0] v_fb, h_fb, disp_addr;
  wr_req_t           head;

  // 160 = 128 + 32, so the row base is two shifts and an add
  assign v_fb      = ADDR_W'(v_count >> 2);
  assign h_fb      = ADDR_W'(h_count >> 2);
  assign disp_addr = (v_fb << 7) + (v_fb << 5) + h_fb;

  assign disp_slot = bright && (h_count[1:0] == 2'd0) && (h_count < 10'(H_ACTIVE));
  assign vblank_ok = !wr_vblank_only || (v_count >= 10'(V_ACTIVE));

  assign full     = (cnt_q == (PTR_W+1)'(FIFO_DEPTH));
  assign empty    = (cnt_q == '0);
  assign wr_ready = rdy_en_q && !full;
  assign push     = wr_valid && wr_ready;
  assign pop      = !disp_slot && !empty && vblank_ok;
  assign cnt_d    = cnt_q + (PTR_W+1)'(push) - (PTR_W+1)'(pop);

  assign head       = mem_q[rd_ptr_q];
  assign head_in_fb = (head.addr < FB_SIZE);
  assign fifo_count = 3'(cnt_q);

  // Out-of-range entries still pop; the RAM just sees a harmless display read
  always_comb begin
    ram_we    = 1'b0;
    ram_addr  = disp_addr;
    ram_wdata = 3'd0;
    if (pop && head_in_fb) begin
      ram_we    = 1'b1;
      ram_addr  = head.addr;
      ram_wdata = head.data;
    end
    if (!reset_n) begin
      ram_we    = 1'b0;
      ram_addr  = '0;
      ram_wdata = 3'd0;
    end
  end

  always_ff @(posedge clk_25) begin
    if (push) mem_q[wr_ptr_q] <= '{addr: wr_addr, data: wr_data};
  end

  always_ff @(posedge clk_25 or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      cnt_q       <= '0;
      rdy_en_q    <= 1'b0;
      slot_d1_q   <= 1'b0;
      bright_d1_q <= 1'b0;
      pix_q       <= 3'd0;
    end else begin
      rdy_en_q    <= 1'b1;
      cnt_q       <= cnt_d;
      if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      slot_d1_q   <= disp_slot;
      bright_d1_q <= bright;
      if (slot_d1_q) pix_q <= ram_rdata;
    end
  end

  // The slot cycle shows fresh RAM data; the other three reuse the latched pixel
  assign rgb = bright_d1_q ? (slot_d1_q ? ram_rdata : pix_q) : 3'd0;

endmodule

// File: tb/tb_vga_fb_arbiter.sv
// Randomized bench for vga_fb_arbiter: a framebuffer reference model plus
// write and pixel scoreboards drained by an independent negedge monitor.
module tb_vga_fb_arbiter;
  localparam int ADDR_W = 15;
  localparam int FB_PIX = 19200;

  logic              clk_25 = 1'b0;
  logic              reset_n = 1'b0;
  logic [9:0]        h_count = '0, v_count = '0;
  logic              bright = 1'b0, wr_valid = 1'b0, wr_vblank_only = 1'b0;
  logic [ADDR_W-1:0] wr_addr = '0;
  logic [2:0]        wr_data = '0;
  logic              wr_ready, ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [2:0]        ram_wdata, ram_rdata, rgb, fifo_count;

  vga_fb_arbiter dut (
    .clk_25(clk_25), .reset_n(reset_n), .h_count(h_count), .v_count(v_count),
    .bright(bright), .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr),
    .wr_data(wr_data), .wr_vblank_only(wr_vblank_only), .ram_addr(ram_addr),
    .ram_we(ram_we), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata), .rgb(rgb),
    .fifo_count(fifo_count)
  );

  always #20 clk_25 = ~clk_25;

  typedef struct { int due; logic [2:0] val; } rgb_exp_t;

  int          n_chk = 0, n_fail = 0, cyc = 0, we_cnt = 0;
  bit          sweeping = 1'b0, sweep_done = 1'b0;
  logic [17:0] exp_wr[$];
  rgb_exp_t    exp_rgb[$];
  logic [2:0]  fb [0:FB_PIX-1];
  logic [2:0]  ram [0:32767];
  bit          ram_vld [0:32767];

  function automatic logic [2:0] seed_pix(input int i);
    return 3'((i * 5) ^ (i >> 7));
  endfunction

  // Synchronous single-port RAM with read-before-write, preloaded by seed_pix
  always @(posedge clk_25) begin
    ram_rdata <= ram_vld[ram_addr] ? ram[ram_addr] : seed_pix(int'(ram_addr));
    if (ram_we) begin
      ram[ram_addr]     <= ram_wdata;
      ram_vld[ram_addr] <= 1'b1;
    end
  end

  always @(posedge clk_25) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic accept(input int a, input logic [2:0] d);
    if (a < FB_PIX) begin
      exp_wr.push_back({15'(a), d});
      fb[a] = d;
    end
  endtask

  // Called at posedge+1; returns at posedge+1 right after the accepting edge
  task automatic push_write(input int a, input logic [2:0] d);
    wr_valid = 1'b1; wr_addr = 15'(a); wr_data = d;
    for (int t = 0; t < 50; t++) begin
      @(negedge clk_25);
      if (wr_ready) begin
        accept(a, d);
        @(posedge clk_25); #1;
        wr_valid = 1'b0;
        return;
      end
      @(posedge clk_25); #1;
    end
    n_chk++; n_fail++;
    $display("FAIL push_timeout: got wr_ready=0 for 50 cycles expected acceptance");
    wr_valid = 1'b0;
  endtask

  task automatic drive(input int h, input int v, input bit b, input bit score);
    rgb_exp_t e;
    h_count = 10'(h); v_count = 10'(v); bright = b;
    if (score) begin
      e.due = cyc + 1;
      e.val = 3'd0;
      if (b) e.val = fb[(v / 4) * 160 + h / 4];
      exp_rgb.push_back(e);
    end
  endtask

  task automatic tick();
    @(posedge clk_25); #1;
  endtask

  // Monitor: checks every RAM cycle and every scored pixel
  initial begin
    logic [17:0] e;
    rgb_exp_t    r;
    forever begin
      @(negedge clk_25);
      if (reset_n) begin
        if (bright && h_count[1:0] == 2'd0) begin
          chk("slot_we", ram_we, 0);
          chk("slot_addr", ram_addr, (v_count / 4) * 160 + h_count / 4);
        end else if (sweeping && fifo_count != 0 && !wr_vblank_only) begin
          chk("free_cycle_we", ram_we, 1);
        end
        if (ram_we) begin
          we_cnt++;
          if (exp_wr.size() == 0) begin
            n_chk++; n_fail++;
            $display("FAIL wr_unexpected: got write addr=%0d data=%0d expected none", ram_addr, ram_wdata);
          end else begin
            e = exp_wr.pop_front();
            chk("wr_addr", ram_addr, e[17:3]);
            chk("wr_data", ram_wdata, e[2:0]);
          end
        end
        while (exp_rgb.size() > 0 && exp_rgb[0].due <= cyc) begin
          r = exp_rgb.pop_front();
          chk("rgb", rgb, r.val);
        end
      end
    end
  end

  initial begin
    #4_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int w0, lines[4];
    for (int i = 0; i < FB_PIX; i++) fb[i] = seed_pix(i);

    // Reset with a pending request and a nonzero display position
    wr_valid = 1'b1; bright = 1'b1; h_count = 10'd40; v_count = 10'd40;
    repeat (3) @(posedge clk_25); #1;
    chk("rst_rgb", rgb, 0);
    chk("rst_we", ram_we, 0);
    chk("rst_count", fifo_count, 0);
    chk("rst_ready", wr_ready, 0);
    chk("rst_addr", ram_addr, 0);
    chk("rst_wdata", ram_wdata, 0);
    wr_valid = 1'b0;
    drive(0, 0, 0, 0);
    reset_n = 1'b1;
    @(negedge clk_25);
    chk("ready_before_clk", wr_ready, 0);
    tick();
    chk("ready_after_clk", wr_ready, 1);

    // Single write during blanking appears one clock after acceptance
    push_write(0, 3'b101);
    @(negedge clk_25);
    chk("lat_we", ram_we, 1);
    chk("lat_addr", ram_addr, 0);
    chk("lat_wdata", ram_wdata, 5);
    tick();
    for (int h = 0; h < 4; h++) begin drive(h, 0, 1, 1); tick(); end
    drive(700, 0, 0, 1); tick();
    drive(700, 0, 0, 1); tick();

    // Tear-free mode: writes held until vertical blanking
    wr_vblank_only = 1'b1;
    drive(700, 100, 0, 0);
    w0 = we_cnt;
    for (int i = 0; i < 4; i++) push_write($urandom_range(0, FB_PIX - 1), 3'($urandom));
    chk("vb_no_we", we_cnt, w0);
    @(negedge clk_25);
    chk("vb_full_ready", wr_ready, 0);
    chk("vb_full_count", fifo_count, 4);
    chk("vb_full_we", ram_we, 0);
    tick();
    drive(700, 480, 0, 0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk_25);
      chk("vb_drain_we", ram_we, 1);
      chk("vb_drain_count", fifo_count, 4 - i);
    end
    @(negedge clk_25);
    chk("vb_empty_count", fifo_count, 0);
    chk("vb_empty_ready", wr_ready, 1);
    chk("vb_empty_we", ram_we, 0);
    tick();

    // Out-of-range entry is dropped, next one is written
    wr_vblank_only = 1'b0;
    drive(700, 100, 0, 0);
    push_write(FB_PIX, 3'd3);
    @(negedge clk_25);
    chk("drop_we", ram_we, 0);
    chk("drop_count", fifo_count, 1);
    tick();
    push_write(5, 3'd6);
    @(negedge clk_25);
    chk("after_drop_we", ram_we, 1);
    chk("after_drop_addr", ram_addr, 5);
    chk("after_drop_wdata", ram_wdata, 6);
    tick();

    // Full line at v=9 with a saturating random write stream
    sweeping = 1'b1; sweep_done = 1'b0;
    fork
      begin
        for (int h = 0; h < 800; h++) begin
          drive(h, 9, h < 640, 0);
          if (h == 12) begin
            @(negedge clk_25);
            chk("h12_addr", ram_addr, 323);
            chk("h12_we", ram_we, 0);
          end
          tick();
        end
        sweep_done = 1'b1;
      end
      begin
        int a;
        logic [2:0] d;
        a = $urandom_range(0, FB_PIX - 1); d = 3'($urandom);
        wr_valid = 1'b1; wr_addr = 15'(a); wr_data = d;
        while (!sweep_done) begin
          @(negedge clk_25);
          if (wr_ready) begin
            accept(a, d);
            tick();
            a = $urandom_range(0, FB_PIX - 1); d = 3'($urandom);
            wr_addr = 15'(a); wr_data = d;
          end else begin
            tick();
          end
        end
        wr_valid = 1'b0;
      end
    join
    sweeping = 1'b0;
    drive(700, 500, 0, 0);
    for (int t = 0; t < 20 && fifo_count != 0; t++) tick();
    @(negedge clk_25);
    chk("sweep_drained", fifo_count, 0);
    chk("sweep_wr_left", exp_wr.size(), 0);
    tick();

    // Scan several full lines, including the first and last framebuffer rows
    lines[0] = 0; lines[1] = 479;
    lines[2] = $urandom_range(1, 478); lines[3] = $urandom_range(1, 478);
    foreach (lines[l]) begin
      for (int h = 0; h < 800; h++) begin drive(h, lines[l], h < 640, 1); tick(); end
    end
    drive(700, 500, 0, 0);
    tick(); tick();
    chk("rgb_all_seen", exp_rgb.size(), 0);

    // Reset mid-drain discards the remaining queue
    wr_vblank_only = 1'b1;
    drive(700, 100, 0, 0);
    for (int i = 0; i < 3; i++) push_write($urandom_range(0, FB_PIX - 1), 3'($urandom));
    drive(700, 480, 0, 0);
    @(negedge clk_25);
    chk("mid_drain_we", ram_we, 1);
    chk("mid_drain_count", fifo_count, 3);
    tick();
    reset_n = 1'b0;
    #1;
    chk("mid_rst_count", fifo_count, 0);
    chk("mid_rst_we", ram_we, 0);
    chk("mid_rst_ready", wr_ready, 0);
    exp_wr.delete();
    w0 = we_cnt;
    tick(); tick();
    reset_n = 1'b1;
    repeat (10) tick();
    chk("post_rst_no_we", we_cnt, w0);
    chk("post_rst_count", fifo_count, 0);
    chk("post_rst_ready", wr_ready, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
